// File: rtl/e203_dtcm_ctx_defines.sv
// Shared definitions for the DTCM context save/restore scheduler.
// Optional checksum word: define E203_DTCM_CTX_CHKSUM_EN.
package e203_dtcm_ctx_defines;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    RDONE   = 2'd3
  } ctx_state_e;

  localparam int          CTX_NREG      = 16;
  localparam int unsigned CTX_BASE_DFLT = 32'h3F00;

  // One extra bit so the checksum slot at index NREG fits when NREG=32
  localparam int CTX_CW = 6;

`ifdef E203_DTCM_CTX_CHKSUM_EN
  localparam bit CTX_CHK = 1'b1;
`else
  localparam bit CTX_CHK = 1'b0;
`endif

endpackage

// File: rtl/e203_dtcm_ctx_seq.sv
// Context save/restore sequencer: FSM, word counter, pending events.
// Checksum word added when E203_DTCM_CTX_CHKSUM_EN is defined.
module e203_dtcm_ctx_seq
  import e203_dtcm_ctx_defines::*;
#(
  parameter int          AW       = 14,
  parameter int          DW       = 32,
  parameter int          MW       = 4,
  parameter int          NREG     = CTX_NREG,
  parameter int unsigned CTX_BASE = CTX_BASE_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          irq_i,
  input  logic          mret_i,
  input  logic [DW-1:0] ctx_rf_rdata,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          core_gnt,
  output logic          eng_cs,
  output logic          eng_we,
  output logic [AW-1:0] eng_addr,
  output logic [MW-1:0] eng_wem,
  output logic [DW-1:0] eng_din,
  output logic [4:0]    ctx_rf_idx,
  output logic          ctx_rf_wen,
  output logic [DW-1:0] ctx_rf_wdata,
`ifdef E203_DTCM_CTX_CHKSUM_EN
  output logic          ctx_err,
`endif
  output logic          irq_regsave,
  output logic          mret_restore
);

  typedef logic [CTX_CW-1:0] cnt_t;

  localparam int   LAST     = NREG - 1 + int'(CTX_CHK);
  localparam cnt_t CNT_LAST = cnt_t'(LAST);
  localparam cnt_t CNT_NREG = cnt_t'(NREG);

  ctx_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       ridx_q, ridx_d;
  logic       rvld_q, rvld_d;
  logic       irq_pend_q, irq_pend_d;
  logic       mret_pend_q, mret_pend_d;
  logic       sdone_q, sdone_d;
  logic       irq_any, mret_any, last;

`ifdef E203_DTCM_CTX_CHKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign irq_any     = irq_i | irq_pend_q;
  assign mret_any    = mret_i | mret_pend_q;
  assign last        = (cnt_q == CNT_LAST);
  assign busy        = (state_q != IDLE);
  assign core_gnt    = (state_q == IDLE) & ~(irq_any | mret_any);
  assign irq_regsave = sdone_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ridx_d       = cnt_q;
    rvld_d       = 1'b0;
    irq_pend_d   = irq_pend_q | (busy & irq_i);
    mret_pend_d  = mret_pend_q | (busy & mret_i);
    sdone_d      = 1'b0;
    eng_cs       = 1'b0;
    eng_we       = 1'b0;
    eng_wem      = '0;
    eng_addr     = AW'(CTX_BASE + 32'(cnt_q));
    eng_din      = '0;
    ctx_rf_idx   = '0;
    ctx_rf_wdata = '0;
    mret_restore = 1'b0;
    // Slot NREG is the checksum word, never written to the regfile
    ctx_rf_wen   = rvld_q && (ridx_q != CNT_NREG);
`ifdef E203_DTCM_CTX_CHKSUM_EN
    csum_d       = csum_q;
    ctx_err      = 1'b0;
`endif
    if (ctx_rf_wen) begin
      ctx_rf_idx   = ridx_q[4:0];
      ctx_rf_wdata = ram_dout;
`ifdef E203_DTCM_CTX_CHKSUM_EN
      csum_d       = csum_q ^ ram_dout;
`endif
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef E203_DTCM_CTX_CHKSUM_EN
        csum_d = '0;
`endif
        if (irq_any) begin
          state_d     = SAVE;
          irq_pend_d  = 1'b0;
          mret_pend_d = mret_any;
        end else if (mret_any) begin
          state_d     = RESTORE;
          mret_pend_d = 1'b0;
        end
      end
      SAVE: begin
        eng_cs     = 1'b1;
        eng_we     = 1'b1;
        eng_wem    = '1;
        ctx_rf_idx = cnt_q[4:0];
        eng_din    = ctx_rf_rdata;
`ifdef E203_DTCM_CTX_CHKSUM_EN
        csum_d = csum_q ^ ctx_rf_rdata;
        if (cnt_q == CNT_NREG) eng_din = csum_q;
`endif
        cnt_d = cnt_q + cnt_t'(1);
        if (last) begin
          state_d = IDLE;
          sdone_d = 1'b1;
        end
      end
      RESTORE: begin
        eng_cs = 1'b1;
        rvld_d = 1'b1;
        cnt_d  = cnt_q + cnt_t'(1);
        if (last) state_d = RDONE;
      end
      RDONE: begin
        mret_restore = 1'b1;
        state_d      = IDLE;
`ifdef E203_DTCM_CTX_CHKSUM_EN
        ctx_err = rvld_q && (ridx_q == CNT_NREG) && (ram_dout != csum_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ridx_q      <= '0;
      rvld_q      <= 1'b0;
      irq_pend_q  <= 1'b0;
      mret_pend_q <= 1'b0;
      sdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ridx_q      <= ridx_d;
      rvld_q      <= rvld_d;
      irq_pend_q  <= irq_pend_d;
      mret_pend_q <= mret_pend_d;
      sdone_q     <= sdone_d;
    end
  end

`ifdef E203_DTCM_CTX_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

endmodule

// File: rtl/e203_dtcm_ctx_sched.sv
// DTCM port scheduler between core data path and context engine.
// Adds ctx_err output when E203_DTCM_CTX_CHKSUM_EN is defined.
module e203_dtcm_ctx_sched
  import e203_dtcm_ctx_defines::*;
#(
  parameter int          AW       = 14,
  parameter int          DW       = 32,
  parameter int          MW       = 4,
  parameter int          NREG     = CTX_NREG,
  parameter int unsigned CTX_BASE = CTX_BASE_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_cmd_valid,
  output logic          core_cmd_ready,
  input  logic          core_cmd_read,
  input  logic [AW-1:0] core_cmd_addr,
  input  logic [DW-1:0] core_cmd_wdata,
  input  logic [MW-1:0] core_cmd_wmask,
  output logic          core_rsp_valid,
  output logic [DW-1:0] core_rsp_rdata,
  input  logic          irq_i,
  input  logic          mret_i,
  output logic [4:0]    ctx_rf_idx,
  input  logic [DW-1:0] ctx_rf_rdata,
  output logic          ctx_rf_wen,
  output logic [DW-1:0] ctx_rf_wdata,
  output logic          irq_regsave,
  output logic          mret_restore,
`ifdef E203_DTCM_CTX_CHKSUM_EN
  output logic          ctx_err,
`endif
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          core_gnt;
  logic          eng_cs, eng_we;
  logic [AW-1:0] eng_addr;
  logic [MW-1:0] eng_wem;
  logic [DW-1:0] eng_din;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_rd_q, rsp_rd_d;

  e203_dtcm_ctx_seq #(
    .AW       (AW),
    .DW       (DW),
    .MW       (MW),
    .NREG     (NREG),
    .CTX_BASE (CTX_BASE)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq_i),
    .mret_i       (mret_i),
    .ctx_rf_rdata (ctx_rf_rdata),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .core_gnt     (core_gnt),
    .eng_cs       (eng_cs),
    .eng_we       (eng_we),
    .eng_addr     (eng_addr),
    .eng_wem      (eng_wem),
    .eng_din      (eng_din),
    .ctx_rf_idx   (ctx_rf_idx),
    .ctx_rf_wen   (ctx_rf_wen),
    .ctx_rf_wdata (ctx_rf_wdata),
`ifdef E203_DTCM_CTX_CHKSUM_EN
    .ctx_err      (ctx_err),
`endif
    .irq_regsave  (irq_regsave),
    .mret_restore (mret_restore)
  );

  // Held low during reset so every output reads zero
  assign core_cmd_ready = rst_n & core_gnt;

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (busy) begin
      ram_cs   = eng_cs;
      ram_we   = eng_we;
      ram_addr = eng_addr;
      ram_wem  = eng_wem;
      ram_din  = eng_din;
    end else if (core_cmd_ready) begin
      ram_cs   = core_cmd_valid;
      ram_we   = core_cmd_valid & ~core_cmd_read;
      ram_addr = core_cmd_addr;
      ram_wem  = core_cmd_wmask;
      ram_din  = core_cmd_wdata;
    end
  end

  assign rsp_vld_d = core_cmd_valid & core_cmd_ready;
  assign rsp_rd_d  = core_cmd_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_rd_q  <= rsp_rd_d;
    end
  end

  assign core_rsp_valid = rsp_vld_q;
  assign core_rsp_rdata = (rsp_vld_q & rsp_rd_q) ? ram_dout : '0;

endmodule

// File: tb/tb_e203_dtcm_ctx_sched.sv
// Scoreboard bench for e203_dtcm_ctx_sched.
// Checksum cases built when E203_DTCM_CTX_CHKSUM_EN is defined.
module tb_e203_dtcm_ctx_sched;
  import e203_dtcm_ctx_defines::*;

  localparam int AW      = 14;
  localparam int DW      = 32;
  localparam int MW      = 4;
  localparam int NREG    = 16;
  localparam int BASE    = 'h3F00;
  localparam int CHK     = int'(CTX_CHK);
  localparam int DONE_AT = NREG + 1 + CHK;

  logic          clk, rst_n;
  logic          core_cmd_valid, core_cmd_ready, core_cmd_read;
  logic [AW-1:0] core_cmd_addr;
  logic [DW-1:0] core_cmd_wdata;
  logic [MW-1:0] core_cmd_wmask;
  logic          core_rsp_valid;
  logic [DW-1:0] core_rsp_rdata;
  logic          irq_i, mret_i;
  logic [4:0]    ctx_rf_idx;
  logic [DW-1:0] ctx_rf_rdata, ctx_rf_wdata;
  logic          ctx_rf_wen, irq_regsave, mret_restore, busy;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ctx_err_s;

  e203_dtcm_ctx_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_cmd_valid (core_cmd_valid),
    .core_cmd_ready (core_cmd_ready),
    .core_cmd_read  (core_cmd_read),
    .core_cmd_addr  (core_cmd_addr),
    .core_cmd_wdata (core_cmd_wdata),
    .core_cmd_wmask (core_cmd_wmask),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_rdata (core_rsp_rdata),
    .irq_i          (irq_i),
    .mret_i         (mret_i),
    .ctx_rf_idx     (ctx_rf_idx),
    .ctx_rf_rdata   (ctx_rf_rdata),
    .ctx_rf_wen     (ctx_rf_wen),
    .ctx_rf_wdata   (ctx_rf_wdata),
    .irq_regsave    (irq_regsave),
    .mret_restore   (mret_restore),
`ifdef E203_DTCM_CTX_CHKSUM_EN
    .ctx_err        (ctx_err_s),
`endif
    .busy           (busy),
    .ram_cs         (ram_cs),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wem        (ram_wem),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout)
  );

`ifndef E203_DTCM_CTX_CHKSUM_EN
  assign ctx_err_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rf  [0:31];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  assign ctx_rf_rdata = rf[ctx_rf_idx];
  always @(posedge clk)
    if (ctx_rf_wen) rf[ctx_rf_idx] = ctx_rf_wdata;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  pair_t       ramw_q[$];
  pair_t       rfw_q[$];
  logic [31:0] rsp_q[$];
  int          n_chk, n_pass;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] val(input int base, input int i);
    return 32'(base + i);
  endfunction

  function automatic logic [31:0] xorv(input int base);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < NREG; i++) x ^= val(base, i);
    return x;
  endfunction

  always @(negedge clk) begin
    pair_t       p;
    logic [31:0] e;
    if (rst_n) begin
      if (core_rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexp", 32'(core_rsp_valid), 0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", core_rsp_rdata, e);
        end
      end
      if (busy && ram_cs && ram_we) begin
        if (ramw_q.size() == 0) check("ramw_unexp", 32'(ram_we), 0);
        else begin
          p = ramw_q.pop_front();
          check("ramw_addr", 32'(ram_addr), p.a);
          check("ramw_data", ram_din, p.d);
        end
      end
      if (ctx_rf_wen) begin
        if (rfw_q.size() == 0) check("rfw_unexp", 32'(ctx_rf_wen), 0);
        else begin
          p = rfw_q.pop_front();
          check("rfw_idx", 32'(ctx_rf_idx), p.a);
          check("rfw_data", ctx_rf_wdata, p.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf(input int base);
    for (int i = 0; i < 32; i++) rf[i] = val(base, i);
  endtask

  task automatic push_save(input int base, input int n);
    for (int i = 0; i < n; i++) ramw_q.push_back({32'(BASE + i), val(base, i)});
    if (n == NREG && CHK == 1)
      ramw_q.push_back({32'(BASE + NREG), xorv(base)});
  endtask

  task automatic push_rest(input int base, input int bad);
    for (int i = 0; i < NREG; i++)
      rfw_q.push_back({32'(i), val(base, i) ^ 32'(i == bad)});
  endtask

  task automatic run(input int ncyc, input int x1, input int x2,
                     output int rs_at, output int mr_at,
                     output int rs_n, output int mr_n,
                     output int nrdy, output logic err);
    rs_at = -1; mr_at = -1; rs_n = 0; mr_n = 0; nrdy = 0; err = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (irq_regsave) begin
        if (rs_at < 0) rs_at = k;
        rs_n++;
      end
      if (mret_restore) begin
        if (mr_at < 0) mr_at = k;
        mr_n++;
        err = err | ctx_err_s;
      end
      if (!core_cmd_ready) nrdy++;
      step();
      core_cmd_valid = 1'b0;
      mret_i = 1'b0;
      irq_i = (k + 1 == x1) || (k + 1 == x2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   rs_at, mr_at, rs_n, mr_n, nrdy;
    logic err;
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem['h10] = 32'hA5A5_0001;
    mem['h20] = 32'hFFFF_FFFF;
    load_rf(0);
    ram_dout = '0;
    rst_n = 1'b0;
    core_cmd_valid = 1'b0; core_cmd_read = 1'b0;
    core_cmd_addr = '0; core_cmd_wdata = '0; core_cmd_wmask = '0;
    irq_i = 1'b0; mret_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(core_cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;

    // core read and masked write while idle
    step();
    core_cmd_valid = 1'b1; core_cmd_read = 1'b1; core_cmd_addr = 'h10;
    rsp_q.push_back(32'hA5A5_0001);
    @(negedge clk);
    check("rd_ready", 32'(core_cmd_ready), 1);
    step();
    core_cmd_read = 1'b0; core_cmd_addr = 'h20;
    core_cmd_wdata = 32'h1234_5678; core_cmd_wmask = 4'b0011;
    rsp_q.push_back(32'h0);
    @(negedge clk);
    step();
    core_cmd_read = 1'b1;
    rsp_q.push_back(32'hFFFF_5678);
    @(negedge clk);
    step();
    core_cmd_valid = 1'b0;
    repeat (2) step();

    // save: irq cycle plus the save cycles stall the core
    load_rf('h100);
    push_save('h100, NREG);
    irq_i = 1'b1;
    run(30, -1, -1, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("save_done_at", 32'(rs_at), 32'(DONE_AT));
    check("save_done_n", 32'(rs_n), 1);
    check("save_stall", 32'(nrdy), 32'(DONE_AT));
    check("save_no_rest", 32'(mr_n), 0);

    // restore into a cleared regfile
    load_rf(0);
    push_rest('h100, -1);
    mret_i = 1'b1;
    run(30, -1, -1, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("rest_done_at", 32'(mr_at), 32'(DONE_AT));
    check("rest_done_n", 32'(mr_n), 1);
    check("rest_rf5", rf[5], 32'h105);
`ifdef E203_DTCM_CTX_CHKSUM_EN
    check("rest_err", 32'(err), 0);
`endif

    // irq and mret together: save, then restore right after
    load_rf('h200);
    push_save('h200, NREG);
    push_rest('h200, -1);
    irq_i = 1'b1; mret_i = 1'b1;
    run(60, -1, -1, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("both_save_at", 32'(rs_at), 32'(DONE_AT));
    check("both_rest_at", 32'(mr_at), 32'(2 * DONE_AT));
    check("both_save_n", 32'(rs_n), 1);
    check("both_rest_n", 32'(mr_n), 1);

    // core write, then restore with two irqs absorbed into one save
    step();
    core_cmd_valid = 1'b1; core_cmd_read = 1'b0; core_cmd_addr = 'h30;
    core_cmd_wdata = 32'hDEAD_BEEF; core_cmd_wmask = 4'hF;
    rsp_q.push_back(32'h0);
    push_rest('h200, -1);
    push_save('h200, NREG);
    @(negedge clk);
    check("wr_ready", 32'(core_cmd_ready), 1);
    step();
    core_cmd_valid = 1'b0;
    mret_i = 1'b1;
    run(80, 3, 6, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("pend_rest_n", 32'(mr_n), 1);
    check("pend_save_n", 32'(rs_n), 1);
    check("pend_save_at", 32'(rs_at), 32'(2 * DONE_AT + 1));
    core_cmd_valid = 1'b1; core_cmd_read = 1'b1; core_cmd_addr = 'h30;
    rsp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    step();
    core_cmd_valid = 1'b0;

    // reset in the middle of a save at word 7
    load_rf('h400);
    push_save('h400, 7);
    irq_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      step();
      irq_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({core_cmd_ready, core_rsp_valid, ctx_rf_wen,
                            irq_regsave, mret_restore, busy, ram_cs,
                            ram_we, ram_wem, ctx_rf_idx}), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_data", ram_din | core_rsp_rdata | ctx_rf_wdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("part_w6", mem[BASE + 6], val('h400, 6));
    check("part_w7", mem[BASE + 7], val('h200, 7));
    @(negedge clk);
    check("post_ready", 32'(core_cmd_ready), 1);
    check("post_busy", 32'(busy), 0);
    repeat (3) step();
    @(negedge clk);
    check("post_idle", 32'({busy, irq_regsave, mret_restore}), 0);
    step();

`ifdef E203_DTCM_CTX_CHKSUM_EN
    load_rf('h500);
    push_save('h500, NREG);
    irq_i = 1'b1;
    run(40, -1, -1, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("chk_save_n", 32'(rs_n), 1);
    mem[BASE + 3] = mem[BASE + 3] ^ 32'h1;
    load_rf(0);
    push_rest('h500, 3);
    mret_i = 1'b1;
    run(40, -1, -1, rs_at, mr_at, rs_n, mr_n, nrdy, err);
    check("chk_rest_n", 32'(mr_n), 1);
    check("chk_err", 32'(err), 1);
`endif

    repeat (2) step();
    check("rsp_q_left", 32'(rsp_q.size()), 0);
    check("ramw_q_left", 32'(ramw_q.size()), 0);
    check("rfw_q_left", 32'(rfw_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
